// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and a level interrupt.
// The bus slave accepts one transfer per two cycles: a single wait cycle, then a one-cycle ack.
module bus_timer #(
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic        bus_read,
  output logic [31:0] bus_readdata,
  output logic [1:0]  bus_response,
  input  logic        bus_write,
  input  logic [31:0] bus_writedata,
  input  logic [3:0]  bus_byteenable,
  output logic        bus_waitrequest,
  output logic        irq
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_LOAD     = 3'd1;
  localparam logic [2:0] A_COUNT    = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
  localparam logic [2:0] A_PRESCALE = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [0:0]            state_q, state_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [1:0]            response_q, response_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           count_q, count_d;
  logic                  expired_q, expired_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic                  irq_q, irq_d;

  logic [2:0]  addr;
  logic        accept, wr_en, tick, expired_set, expired_clr, addr_valid;
  logic [31:0] reg_rdata, wr_merged;
  logic        unused_addr_bits;

  assign addr             = bus_addr[4:2];
  assign unused_addr_bits = ^{bus_addr[31:5], bus_addr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default at the top so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    readdata_d  = readdata_q;
    response_d  = response_q;
    ctrl_d      = ctrl_q;
    load_d      = load_q;
    count_d     = count_q;
    prescale_d  = prescale_q;
    presc_cnt_d = presc_cnt_q;
    expired_set = 1'b0;
    expired_clr = 1'b0;
    addr_valid  = 1'b1;
    reg_rdata   = 32'h0;

    case (addr)
      A_CTRL:     reg_rdata = {29'h0, ctrl_q};
      A_LOAD:     reg_rdata = load_q;
      A_COUNT:    reg_rdata = count_q;
      A_STATUS:   reg_rdata = {31'h0, expired_q};
      A_PRESCALE: reg_rdata = 32'(prescale_q);
      default:    addr_valid = 1'b0;
    endcase
    wr_merged = merge_bytes(reg_rdata, bus_writedata, bus_byteenable);

    accept = (state_q == S_IDLE) && (bus_read || bus_write);
    wr_en  = accept && bus_write && addr_valid;
    state_d = (state_q == S_IDLE && accept) ? S_ACK : S_IDLE;

    tick = ctrl_q[0] && (presc_cnt_q == prescale_q);
    if (ctrl_q[0]) presc_cnt_d = tick ? '0 : presc_cnt_q + PRESCALE_W'(1);
    if (tick) begin
      if (count_q != 32'h0) begin
        count_d = count_q - 32'd1;
      end else begin
        expired_set = 1'b1;
        if (ctrl_q[1]) count_d = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    if (accept) begin
      response_d = addr_valid ? RESP_OKAY : RESP_SLVERR;
      readdata_d = (bus_write || !addr_valid) ? 32'h0 : reg_rdata;
    end

    // Bus writes are applied after the timer update so they override an expiry-driven EN clear.
    if (wr_en) begin
      case (addr)
        A_CTRL: begin
          ctrl_d = wr_merged[2:0];
          if (!ctrl_q[0] && wr_merged[0]) begin
            count_d     = load_q;
            presc_cnt_d = '0;
          end
        end
        A_LOAD:     load_d      = wr_merged;
        A_STATUS:   expired_clr = bus_byteenable[0] && bus_writedata[0];
        A_PRESCALE: prescale_d  = wr_merged[PRESCALE_W-1:0];
        default:    ;
      endcase
    end

    expired_d = expired_set || (expired_q && !expired_clr);
    irq_d     = expired_q && ctrl_q[2];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      readdata_q  <= 32'h0;
      response_q  <= RESP_OKAY;
      ctrl_q      <= 3'h0;
      load_q      <= RESET_LOAD;
      count_q     <= 32'h0;
      expired_q   <= 1'b0;
      prescale_q  <= '0;
      presc_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      readdata_q  <= readdata_d;
      response_q  <= response_d;
      ctrl_q      <= ctrl_d;
      load_q      <= load_d;
      count_q     <= count_d;
      expired_q   <= expired_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign bus_waitrequest = (state_q != S_ACK);
  assign bus_readdata    = readdata_q;
  assign bus_response    = response_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer: register access, timer counting,
// one-shot and auto-reload expiry, byte enables, error responses and reset abort.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_addr;
  logic        bus_read;
  logic [31:0] bus_readdata;
  logic [1:0]  bus_response;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic        bus_waitrequest;
  logic        irq;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] CTRL = 32'h00, LOAD = 32'h04, COUNT = 32'h08,
                          STATUS = 32'h0C, PRESCALE = 32'h10;

  bus_timer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_addr        (bus_addr),
    .bus_read        (bus_read),
    .bus_readdata    (bus_readdata),
    .bus_response    (bus_response),
    .bus_write       (bus_write),
    .bus_writedata   (bus_writedata),
    .bus_byteenable  (bus_byteenable),
    .bus_waitrequest (bus_waitrequest),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Returns #1 after the accepting edge; a missing accept is reported as a failure.
  task automatic wait_accept(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus_waitrequest && n < 8);
    check({tag, "_accept"}, {31'h0, bus_waitrequest}, 32'h0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [1:0] resp);
    bus_addr = a; bus_writedata = d; bus_byteenable = be; bus_write = 1'b1;
    wait_accept("wr");
    resp = bus_response;
    bus_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [1:0] r;
    do_write(a, d, 4'hF, r);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output logic wait_after);
    bus_addr = a; bus_read = 1'b1;
    wait_accept("rd");
    data = bus_readdata;
    resp = bus_response;
    bus_read = 1'b0;
    @(posedge clk); #1;
    wait_after = bus_waitrequest;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    logic        w;
    do_read(a, d, r, w);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        w;

    rst_n = 1'b0; bus_addr = 32'h0; bus_read = 1'b0; bus_write = 1'b0;
    bus_writedata = 32'h0; bus_byteenable = 4'h0;
    idle(2);
    check("rst_wait", {31'h0, bus_waitrequest}, 32'h1);
    check("rst_rdata", bus_readdata, 32'h0);
    check("rst_resp", {30'h0, bus_response}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    idle(1);
    rd_check("rst_count", COUNT, 32'h0);
    rd_check("rst_load", LOAD, 32'h0);

    // Auto-reload, tick every cycle: CTRL accepted at E0, count = 5 - k after edge Ek.
    wr(LOAD, 32'd5);
    wr(PRESCALE, 32'd0);
    wr(CTRL, 32'h7);
    rd_check("ar_count_e2", COUNT, 32'd4);
    rd_check("ar_count_e4", COUNT, 32'd2);
    idle(1);
    check("ar_irq_before", {31'h0, irq}, 32'h0);
    rd_check("ar_reload", COUNT, 32'd5);
    check("ar_irq_after", {31'h0, irq}, 32'h1);
    rd_check("ar_expired", STATUS, 32'h1);
    wr(CTRL, 32'h0);
    wr(STATUS, 32'h1);
    check("w1c_irq_low", {31'h0, irq}, 32'h0);
    rd_check("w1c_status", STATUS, 32'h0);

    // One-shot with prescale 3: ticks at E4, E8, E12; expiry at E12 clears EN.
    wr(LOAD, 32'd2);
    wr(PRESCALE, 32'd3);
    wr(CTRL, 32'h5);
    idle(8);
    rd_check("os_count_e10", COUNT, 32'd0);
    rd_check("os_status_e12", STATUS, 32'h0);
    rd_check("os_status_e14", STATUS, 32'h1);
    rd_check("os_ctrl", CTRL, 32'h4);
    rd_check("os_count_hold", COUNT, 32'd0);
    check("os_irq", {31'h0, irq}, 32'h1);
    wr(STATUS, 32'h1);
    wr(CTRL, 32'h0);

    // Byte enables and prescaler width.
    wr(LOAD, 32'h0);
    do_write(LOAD, 32'hAABBCCDD, 4'b0101, r);
    rd_check("be_load", LOAD, 32'h00BB00DD);
    wr(PRESCALE, 32'hFFFFFFFF);
    rd_check("presc_width", PRESCALE, 32'h0000FFFF);

    // LOAD write while running does not disturb COUNT; COUNT is read-only.
    wr(PRESCALE, 32'd1000);
    wr(LOAD, 32'd7);
    wr(CTRL, 32'h1);
    wr(LOAD, 32'd9);
    rd_check("run_count", COUNT, 32'd7);
    do_write(COUNT, 32'h55, 4'hF, r);
    check("count_wr_resp", {30'h0, r}, 32'h0);
    rd_check("count_ro", COUNT, 32'd7);
    rd_check("load_new", LOAD, 32'd9);
    wr(CTRL, 32'h0);

    // Unmapped offsets.
    do_read(32'h18, d, r, w);
    check("off6_data", d, 32'h0);
    check("off6_resp", {30'h0, r}, 32'h2);
    check("off6_wait_back", {31'h0, w}, 32'h1);
    do_write(32'h14, 32'h1234, 4'hF, r);
    check("off5_wr_resp", {30'h0, r}, 32'h2);
    rd_check("off5_nochange", LOAD, 32'd9);

    // Simultaneous read and write is a write.
    bus_addr = LOAD; bus_writedata = 32'hCAFE; bus_byteenable = 4'hF;
    bus_read = 1'b1; bus_write = 1'b1;
    wait_accept("rw");
    bus_read = 1'b0; bus_write = 1'b0;
    idle(1);
    rd_check("rw_is_write", LOAD, 32'hCAFE);

    // LOAD=0 with auto-reload expires every cycle, so the W1C always collides with a set.
    wr(LOAD, 32'h0);
    wr(PRESCALE, 32'h0);
    wr(CTRL, 32'h7);
    wr(STATUS, 32'h1);
    check("w1c_col_irq", {31'h0, irq}, 32'h1);
    rd_check("w1c_col_status", STATUS, 32'h1);
    check("w1c_col_irq2", {31'h0, irq}, 32'h1);

    // Held read: waitrequest toggles 1,0,1,0; reset lands while in ACK.
    bus_addr = STATUS; bus_read = 1'b1;
    check("b2b_w0", {31'h0, bus_waitrequest}, 32'h1);
    idle(1);
    check("b2b_w1", {31'h0, bus_waitrequest}, 32'h0);
    idle(1);
    check("b2b_w2", {31'h0, bus_waitrequest}, 32'h1);
    idle(1);
    check("b2b_w3", {31'h0, bus_waitrequest}, 32'h0);
    check("b2b_data", bus_readdata, 32'h1);
    rst_n = 1'b0;
    idle(1);
    bus_read = 1'b0;
    check("ack_rst_wait", {31'h0, bus_waitrequest}, 32'h1);
    check("ack_rst_rdata", bus_readdata, 32'h0);
    check("ack_rst_resp", {30'h0, bus_response}, 32'h0);
    check("ack_rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // A write accepted just before reset does not survive it.
    bus_addr = LOAD; bus_writedata = 32'h1234; bus_byteenable = 4'hF; bus_write = 1'b1;
    wait_accept("abort");
    bus_write = 1'b0;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    rd_check("abort_load", LOAD, 32'h0);
    rd_check("abort_ctrl", CTRL, 32'h0);
    rd_check("abort_status", STATUS, 32'h0);
    rd_check("abort_presc", PRESCALE, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
